// File: rtl/rv32i_wb_cpu.sv
// rv32i_wb_cpu: multi-cycle RV32I core sharing one Wishbone B4 classic master port for fetch and data
module rv32i_wb_cpu #(
  parameter logic [31:0] INITIAL_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic        ack_i,
  input  logic        err_i,
  input  logic        rty_i,
  output logic        stb_o,
  output logic        cyc_o,
  output logic [31:0] adr_o,
  output logic [3:0]  sel_o,
  output logic        we_o
);
  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_WB} state_t;
  state_t state;
  logic [31:0] pc, ir, rdata;
  logic [1:0] ea_lo;
  logic [31:0] rf [32];
  logic [6:0] op;
  logic [4:0] rd, rs1, rs2, sh;
  logic [2:0] f3;
  logic [31:0] a, b, y, imm_i, imm_s, imm_b, imm_u, imm_j, alu, ea, exec_wd, next_pc, wdata, ld, half;
  logic [7:0] lb;
  logic [3:0] sel;
  logic is_load, is_store, is_op, is_opi, is_lui, is_auipc, is_jal, is_jalr, is_br, wr_exec, taken;
  logic rf_we;
  logic [31:0] rf_wd;
  assign op = ir[6:0];
  assign rd = ir[11:7];
  assign f3 = ir[14:12];
  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign is_load = op == 7'b0000011;
  assign is_store = op == 7'b0100011;
  assign is_op = op == 7'b0110011;
  assign is_opi = op == 7'b0010011;
  assign is_lui = op == 7'b0110111;
  assign is_auipc = op == 7'b0010111;
  assign is_jal = op == 7'b1101111;
  assign is_jalr = op == 7'b1100111;
  assign is_br = op == 7'b1100011;
  assign wr_exec = is_lui | is_auipc | is_jal | is_jalr | is_op | is_opi;
  assign a = rs1 == 5'd0 ? 32'h0 : rf[rs1];
  assign b = rs2 == 5'd0 ? 32'h0 : rf[rs2];
  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u = {ir[31:12], 12'h000};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  assign y = is_op ? b : imm_i;
  assign sh = y[4:0];
  always_comb begin
    alu = f3 == 3'd0 ? ((is_op & ir[30]) ? a - y : a + y) :
          f3 == 3'd1 ? a << sh :
          f3 == 3'd2 ? {31'h0, $signed(a) < $signed(y)} :
          f3 == 3'd3 ? {31'h0, a < y} :
          f3 == 3'd4 ? a ^ y :
          f3 == 3'd5 ? (ir[30] ? $unsigned($signed(a) >>> sh) : a >> sh) :
          f3 == 3'd6 ? a | y : a & y;
    taken = f3[2:1] == 2'b00 ? (a == b) ^ f3[0] :
            f3[2:1] == 2'b10 ? ($signed(a) < $signed(b)) ^ f3[0] :
            f3[2:1] == 2'b11 ? (a < b) ^ f3[0] : 1'b0;
    exec_wd = is_lui ? imm_u : is_auipc ? pc + imm_u : (is_jal | is_jalr) ? pc + 32'd4 : alu;
    next_pc = is_jal ? pc + imm_j :
              is_jalr ? (a + imm_i) & ~32'h1 :
              (is_br & taken) ? pc + imm_b : pc + 32'd4;
    ea = a + (is_store ? imm_s : imm_i);
    sel = f3[1:0] == 2'b00 ? 4'b0001 << ea[1:0] :
          f3[1:0] == 2'b01 ? (ea[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata = f3[1:0] == 2'b00 ? {4{b[7:0]}} : f3[1:0] == 2'b01 ? {2{b[15:0]}} : b;
  end
  // Load lane extraction works on the latched bus word and the saved low address bits.
  always_comb begin
    lb = rdata[{ea_lo, 3'b000} +: 8];
    half = ea_lo[1] ? {16'h0, rdata[31:16]} : {16'h0, rdata[15:0]};
    ld = f3 == 3'd0 ? {{24{lb[7]}}, lb} :
         f3 == 3'd1 ? {{16{half[15]}}, half[15:0]} :
         f3 == 3'd4 ? {24'h0, lb} :
         f3 == 3'd5 ? half : rdata;
    rf_we = rd != 5'd0 && ((state == S_EXEC && wr_exec) || (state == S_WB && is_load));
    rf_wd = state == S_WB ? ld : exec_wd;
  end
  always_ff @(posedge clk_i)
    if (rf_we) rf[rd] <= rf_wd;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= S_FETCH;
      pc <= INITIAL_PC;
      ir <= 32'h0;
      rdata <= 32'h0;
      ea_lo <= 2'b00;
      stb_o <= 1'b0;
      cyc_o <= 1'b0;
      we_o <= 1'b0;
      sel_o <= 4'h0;
      adr_o <= 32'h0;
      dat_o <= 32'h0;
    end else begin
      case (state)
        S_FETCH:
          if (!cyc_o) begin
            cyc_o <= 1'b1;
            stb_o <= 1'b1;
            we_o <= 1'b0;
            sel_o <= 4'hF;
            adr_o <= {pc[31:2], 2'b00};
          end else if (ack_i | err_i | rty_i) begin
            cyc_o <= 1'b0;
            stb_o <= 1'b0;
            if (ack_i) begin
              ir <= dat_i;
              state <= S_EXEC;
            end else if (err_i) pc <= pc + 32'd4;
          end
        S_EXEC:
          if (is_load | is_store) begin
            cyc_o <= 1'b1;
            stb_o <= 1'b1;
            we_o <= is_store;
            sel_o <= sel;
            adr_o <= {ea[31:2], 2'b00};
            dat_o <= wdata;
            ea_lo <= ea[1:0];
            state <= S_MEM;
          end else begin
            pc <= next_pc;
            state <= S_FETCH;
          end
        // A retry leaves cyc low for one clock; the held address/lanes are then re-strobed.
        S_MEM:
          if (!cyc_o) begin
            cyc_o <= 1'b1;
            stb_o <= 1'b1;
          end else if (ack_i | err_i | rty_i) begin
            cyc_o <= 1'b0;
            stb_o <= 1'b0;
            if (ack_i) begin
              rdata <= dat_i;
              state <= S_WB;
            end else if (err_i) begin
              pc <= pc + 32'd4;
              state <= S_FETCH;
            end
          end
        S_WB: begin
          pc <= pc + 32'd4;
          state <= S_FETCH;
        end
        default: state <= S_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_rv32i_wb_cpu.sv
// tb_rv32i_wb_cpu: load/store vectors plus bus-termination sequences, checked through a write scoreboard
module tb_rv32i_wb_cpu;
  logic clk_i = 1'b0, rst_i = 1'b0;
  logic [31:0] dat_i = 32'h0, dat_o, adr_o;
  logic ack_i = 1'b0, err_i = 1'b0, rty_i = 1'b0, stb_o, cyc_o, we_o;
  logic [3:0] sel_o;
  always #5 clk_i = ~clk_i;

  rv32i_wb_cpu #(.INITIAL_PC(32'h1000_0000)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .dat_i(dat_i), .dat_o(dat_o), .ack_i(ack_i), .err_i(err_i),
    .rty_i(rty_i), .stb_o(stb_o), .cyc_o(cyc_o), .adr_o(adr_o), .sel_o(sel_o), .we_o(we_o)
  );

  typedef struct { logic [31:0] adr; logic [3:0] sel; logic [31:0] dat; } wr_t;
  typedef struct {
    string nm; logic [31:0] i0, i1, base; int off; logic [2:0] f3; bit st;
    logic [31:0] adr; logic [3:0] sel; logic [31:0] word;
  } vec_t;

  logic [31:0] rom [64];
  logic [31:0] ram [32];
  logic [31:0] init0 = 0, init1 = 0, fault_adr = 32'hFFFF_FFFF;
  int ack_delay = 0, fault_kind = 0, fault_req = 0;
  int faults_done = 0, hits = 0, stall_bad = 0, wait_cnt = 0, wr_n = 0;
  logic [36:0] hold = '0;
  wr_t wlog [256];

  // Wishbone slave: rom at 0x1000_0000, ram at 0x2000_0000, optional stall/retry/error injection
  always @(negedge clk_i) begin
    ack_i = 0; err_i = 0; rty_i = 0; dat_i = 0;
    if (!rst_i) begin
      ram = '{default: 32'h0};
      ram[0] = init0;
      ram[1] = init1;
      wait_cnt = 0;
    end else if (cyc_o && stb_o) begin
      if (wait_cnt == 0) hold = {adr_o, sel_o, we_o};
      else if ({adr_o, sel_o, we_o} != hold) stall_bad++;
      if (wait_cnt < ack_delay) wait_cnt++;
      else begin
        wait_cnt = 0;
        if (adr_o == fault_adr) hits++;
        if (faults_done < fault_req && adr_o == fault_adr) begin
          faults_done++;
          if (fault_kind == 1) rty_i = 1; else err_i = 1;
        end else begin
          ack_i = 1;
          dat_i = adr_o[31:28] == 4'h1 ? rom[adr_o[7:2]] : adr_o[31:28] == 4'h2 ? ram[adr_o[6:2]] : 32'h0;
          if (we_o) begin
            for (int n = 0; n < 4; n++) if (sel_o[n]) ram[adr_o[6:2]][8*n +: 8] = dat_o[8*n +: 8];
            wlog[wr_n % 256] = '{adr_o, sel_o, ram[adr_o[6:2]]};
            wr_n++;
          end
        end
      end
    end else if (wait_cnt != 0) begin
      stall_bad++;
      wait_cnt = 0;
    end
  end

  int total = 0, bad = 0, rd_n = 0;
  wr_t sb [$];
  vec_t vq [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction
  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1, input int f3, input int rd);
    return {f7, rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input int rd, input logic [6:0] op);
    return {imm, rd[4:0], op};
  endfunction

  task automatic add(input string nm, input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] base,
                     input int off, input logic [2:0] f3, input bit st, input logic [31:0] adr,
                     input logic [3:0] sel, input logic [31:0] word);
    vq.push_back('{nm, i0, i1, base, off, f3, st, adr, sel, word});
  endtask

  task automatic build(input vec_t v);
    rom = '{default: 32'h0000_006F};
    rom[0] = enc_u(v.base[31:12], 1, 7'b0110111);
    rom[1] = enc_i(int'(v.base[11:0]), 1, 0, 1, 7'b0010011);
    rom[2] = enc_u(20'hF3F2F, 4, 7'b0110111);
    rom[3] = enc_i(12'h1F0, 4, 0, 4, 7'b0010011);
    rom[4] = v.st ? enc_s(v.off, 4, 1, v.f3) : enc_i(v.off, 1, v.f3, 3, 7'b0000011);
    rom[5] = enc_u(20'h20000, 2, 7'b0110111);
    rom[6] = v.st ? 32'h0000_006F : enc_s(64, 3, 2, 2);
    init0 = v.i0;
    init1 = v.i1;
    sb.push_back('{v.adr, v.sel, v.word});
  endtask

  task automatic start();
    rst_i = 0;
    repeat (2) @(negedge clk_i);
    #1 rst_i = 1;
  endtask

  task automatic run(input string nm);
    int t = 0;
    int need = sb.size();
    while (wr_n - rd_n < need && t < 3000) begin
      @(negedge clk_i);
      t++;
    end
    repeat (20) @(negedge clk_i);
    chk({nm, " write count"}, wr_n - rd_n, need);
    while (sb.size() > 0 && rd_n < wr_n) begin
      wr_t e = sb.pop_front();
      wr_t g = wlog[rd_n % 256];
      rd_n++;
      chk({nm, " adr"}, g.adr, e.adr);
      chk({nm, " sel"}, {28'h0, g.sel}, {28'h0, e.sel});
      chk({nm, " word"}, g.dat, e.dat);
    end
    sb.delete();
    rd_n = wr_n;
  endtask

  initial begin
    int s0, h0;
    logic [31:0] res = 32'h2000_0040;
    add("lw", 32'h1, 0, 32'h2000_0000, 0, 3'd2, 0, res, 4'hF, 32'h1);
    add("lw_neg", 32'h1, 0, 32'h2000_0004, -4, 3'd2, 0, res, 4'hF, 32'h1);
    add("lb0", 32'h8382_8180, 0, 32'h2000_0000, 0, 3'd0, 0, res, 4'hF, 32'hFFFF_FF80);
    add("lbu0", 32'h8382_8180, 0, 32'h2000_0000, 0, 3'd4, 0, res, 4'hF, 32'h0000_0080);
    add("lb1", 32'h0302_0100, 0, 32'h2000_0000, 1, 3'd0, 0, res, 4'hF, 32'h1);
    add("lb2", 32'h0302_0100, 0, 32'h2000_0000, 2, 3'd0, 0, res, 4'hF, 32'h2);
    add("lb3", 32'h0302_0100, 0, 32'h2000_0000, 3, 3'd0, 0, res, 4'hF, 32'h3);
    add("lb_neg", 32'h0302_0100, 0, 32'h2000_0004, -1, 3'd0, 0, res, 4'hF, 32'h3);
    add("lh0", 32'h8382_8180, 0, 32'h2000_0000, 0, 3'd1, 0, res, 4'hF, 32'hFFFF_8180);
    add("lhu0", 32'h8382_8180, 0, 32'h2000_0000, 0, 3'd5, 0, res, 4'hF, 32'h0000_8180);
    add("lh2", 32'h8382_8180, 0, 32'h2000_0000, 2, 3'd1, 0, res, 4'hF, 32'hFFFF_8382);
    add("sw0", 32'h0, 32'hDEAD_BEEF, 32'h2000_0000, 0, 3'd2, 1, 32'h2000_0000, 4'hF, 32'hF3F2_F1F0);
    add("sw4", 32'h0, 32'hDEAD_BEEF, 32'h2000_0000, 4, 3'd2, 1, 32'h2000_0004, 4'hF, 32'hF3F2_F1F0);
    add("sh0", 32'hDEAD_BEEF, 0, 32'h2000_0000, 0, 3'd1, 1, 32'h2000_0000, 4'h3, 32'hDEAD_F1F0);
    add("sh2", 32'hDEAD_BEEF, 0, 32'h2000_0000, 2, 3'd1, 1, 32'h2000_0000, 4'hC, 32'hF1F0_BEEF);
    add("sb0", 32'hDEAD_BEEF, 0, 32'h2000_0000, 0, 3'd0, 1, 32'h2000_0000, 4'h1, 32'hDEAD_BEF0);
    add("sb1", 32'hDEAD_BEEF, 0, 32'h2000_0000, 1, 3'd0, 1, 32'h2000_0000, 4'h2, 32'hDEAD_F0EF);
    add("sb2", 32'hDEAD_BEEF, 0, 32'h2000_0000, 2, 3'd0, 1, 32'h2000_0000, 4'h4, 32'hDEF0_BEEF);
    add("sb3", 32'hDEAD_BEEF, 0, 32'h2000_0000, 3, 3'd0, 1, 32'h2000_0000, 4'h8, 32'hF0AD_BEEF);

    rom = '{default: 32'h0000_006F};
    repeat (2) @(negedge clk_i);
    chk("reset stb", {31'h0, stb_o}, 0);
    chk("reset cyc", {31'h0, cyc_o}, 0);
    chk("reset we", {31'h0, we_o}, 0);
    chk("reset sel", {28'h0, sel_o}, 0);
    chk("reset adr", adr_o, 0);
    chk("reset dat", dat_o, 0);
    #1 rst_i = 1;
    begin
      int t = 0;
      while (!stb_o && t < 20) begin
        @(negedge clk_i);
        t++;
      end
    end
    chk("first fetch stb", {31'h0, stb_o}, 1);
    chk("first fetch adr", adr_o, 32'h1000_0000);
    chk("first fetch sel", {28'h0, sel_o}, 32'hF);
    #2 rst_i = 0;
    #1 chk("async reset cyc", {31'h0, cyc_o}, 0);
    chk("async reset stb", {31'h0, stb_o}, 0);

    foreach (vq[i]) begin
      build(vq[i]);
      start();
      run(vq[i].nm);
    end

    rom = '{default: 32'h0000_006F};
    rom[0] = enc_i(-3, 0, 0, 5, 7'b0010011);
    rom[1] = enc_i(5, 0, 0, 6, 7'b0010011);
    rom[2] = enc_r(7'b0100000, 5, 6, 0, 7);
    rom[3] = enc_i(12'h401, 5, 5, 8, 7'b0010011);
    rom[4] = enc_r(7'b0000000, 5, 6, 3, 9);
    rom[5] = enc_u(20'h20000, 2, 7'b0110111);
    rom[6] = enc_b(8, 5, 6, 1);
    rom[7] = enc_s(76, 6, 2, 2);
    rom[8] = enc_s(64, 7, 2, 2);
    rom[9] = enc_s(68, 8, 2, 2);
    rom[10] = enc_s(72, 9, 2, 2);
    rom[11] = enc_u(20'h00001, 10, 7'b0010111);
    rom[12] = enc_s(76, 10, 2, 2);
    sb.push_back('{32'h2000_0040, 4'hF, 32'h0000_0008});
    sb.push_back('{32'h2000_0044, 4'hF, 32'hFFFF_FFFE});
    sb.push_back('{32'h2000_0048, 4'hF, 32'h0000_0001});
    sb.push_back('{32'h2000_004C, 4'hF, 32'h1000_102C});
    start();
    run("alu");

    ack_delay = 3;
    s0 = stall_bad;
    build(vq[0]);
    start();
    run("ack delay");
    chk("stall stable", stall_bad - s0, 0);
    ack_delay = 0;

    fault_adr = 32'h2000_0000;
    fault_kind = 1;
    fault_req++;
    h0 = hits;
    build(vq[0]);
    start();
    run("retry");
    chk("retry reissue count", hits - h0, 2);

    fault_kind = 2;
    fault_req++;
    rom = '{default: 32'h0000_006F};
    rom[0] = enc_i(12'h055, 0, 0, 3, 7'b0010011);
    rom[1] = enc_u(20'h20000, 1, 7'b0110111);
    rom[2] = enc_i(0, 1, 2, 3, 7'b0000011);
    rom[3] = enc_u(20'h20000, 2, 7'b0110111);
    rom[4] = enc_s(64, 3, 2, 2);
    init0 = 32'h1234_5678;
    sb.push_back('{32'h2000_0040, 4'hF, 32'h0000_0055});
    start();
    run("error");
    chk("error delivered", faults_done, fault_req);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rv32i_wb_cpu.md
Name: rv32i_wb_cpu

Overview:
- Multi-cycle, non-pipelined RV32I integer core with a single Wishbone B4 classic master port.
- The same port carries instruction fetches and data loads/stores, so it is shared with flash and RAM slaves on one bus.
- Holds a 32x32 register file (x0 reads zero) and a program counter; executes one instruction at a time.

Parameters:
- INITIAL_PC, 32'h0000_0000, PC value loaded on reset (the system uses 32'h1000_0000).

Ports:
- clk_i  in  1  system clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- dat_i  in  32  Wishbone read data.
- dat_o  out  32  Wishbone write data.
- ack_i  in  1  cycle acknowledge.
- err_i  in  1  cycle error termination.
- rty_i  in  1  cycle retry request.
- stb_o  out  1  strobe.
- cyc_o  out  1  bus cycle active.
- adr_o  out  32  byte address, always word-aligned (adr_o[1:0]=0).
- sel_o  out  4  byte-lane select; bit n selects dat[8n+7:8n].
- we_o  out  1  1 = write, 0 = read.

Behaviour:
- Reset (rst_i low, asynchronous):
  - PC=INITIAL_PC; state=FETCH_REQ.
  - stb_o=cyc_o=we_o=0; sel_o=0; adr_o=0; dat_o=0.
  - Register file contents are not cleared; x0 always reads 0.
- FETCH:
  - Drive stb_o=cyc_o=1, we_o=0, adr_o=PC, sel_o=4'b1111.
  - Hold these until ack_i, err_i or rty_i is sampled high on a rising edge.
  - On ack: latch dat_i as the instruction, drop stb_o/cyc_o, go to EXECUTE.
- EXECUTE (1 cycle):
  - Decode and compute the ALU result or effective address. Effective address = rs1 + sign-extended imm12.
  - Loads use the I-type immediate; stores use the S-type immediate {inst[31:25],inst[11:7]}.
  - Non-memory instructions write rd and update PC, then return to FETCH.
  - Loads and stores go to MEM.
- MEM:
  - Drive stb_o=cyc_o=1, adr_o={ea[31:2],2'b00}, we_o=1 for stores, and sel_o from funct3 and ea[1:0]:
    - Word: sel_o=1111.
    - Half: ea[1]=0 gives 0011, ea[1]=1 gives 1100.
    - Byte: sel_o=0001<<ea[1:0].
  - Store data: SW passes rs2; SH replicates rs2[15:0] into both halves; SB replicates rs2[7:0] into all four lanes.
  - Load extraction: select the lane(s) indicated by ea[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
  - On ack: drop stb/cyc, latch the read data, then WRITEBACK.
- WRITEBACK (1 cycle): write rd (ignored if rd=0), PC+=4, then FETCH.
- Timing: rd holds the loaded value no later than the second rising edge after the data ack. A store is complete at its ack edge.
- Termination conditions:
  - rty_i: end the cycle for one clock, then reissue the same access.
  - err_i: abandon the access with no register write, PC+=4, then FETCH.
  - If ack_i and err_i arrive together, ack_i has priority.
- Misalignment: a misaligned word access uses the aligned address. A misaligned halfword uses the lane pair selected by ea[1]. No trap is raised for either.
- Instructions:
  - LUI, AUIPC, JAL, JALR (target LSB cleared).
  - BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - All LOAD/STORE widths.
  - OP-IMM and OP: ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND.
  - Shifts use the low 5 bits of the shift amount.
  - FENCE, SYSTEM and unknown opcodes execute as NOPs (PC+=4).
- Arithmetic: 32-bit wrap-around; no overflow detection.
- Reset asserted mid-cycle: the core returns to FETCH immediately and drops stb/cyc asynchronously.

Test Plan:
- LW: x1=0x2000_0000, mem[0x2000_0000]=0x0000_0001, LW x1,0(x1) -> x1=0x0000_0001. With offset -4 from x1=0x2000_0004 -> same word.
- Byte loads, word 0x8382_8180:
  - LB offset 0 -> 0xFFFF_FF80; LBU -> 0x0000_0080.
  - With word 0x0302_0100, LB offsets 1/2/3 -> 1/2/3.
  - x1=0x2000_0004, offset -1 -> 0x03.
- Half loads, word 0x8382_8180:
  - LH 0 -> 0xFFFF_8180; LHU 0 -> 0x0000_8180; LH 2 -> 0xFFFF_8382.
- SW: x1=0xF3F2_F1F0, x2=0x2000_0000, SW x1,0(x2) -> mem[0]=0xF3F2_F1F0, sel_o=1111. With offset 4 -> mem[1] gets the same value.
- SH/SB over 0xDEAD_BEEF with x1=0xF3F2_F1F0:
  - SH off0 -> 0xDEAD_F1F0; SH off2 -> 0xF1F0_BEEF.
  - SB off0/1/2/3 -> 0xDEAD_BEF0 / 0xDEAD_F0EF / 0xDEF0_BEEF / 0xF0AD_BEEF.
- Bus protocol: delay ack 3 cycles -> stb/cyc/adr stay stable. Assert rty once -> access reissued. Assert err on a load -> rd unchanged, next fetch at PC+4.
